// File: rtl/div_seq_op.sv
// Multi-cycle restoring divider for DIV: one trial subtraction per cycle, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module div_seq_op #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quot_out,
  output logic [WIDTH-1:0] rem_out
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StZdiv} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d, b_q, b_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix;
  logic [WIDTH:0]   s, diff;

`ifdef DIV_SIGNED_EN
  logic sign_a_q, sign_a_d, neg_q_q, neg_q_d;

  assign a_mag    = A_reg[WIDTH-1] ? -A_reg : A_reg;
  assign b_mag    = B_reg[WIDTH-1] ? -B_reg : B_reg;
  assign quot_fix = neg_q_q ? -q_q : q_q;
  assign rem_fix  = sign_a_q ? -p_q : p_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sign_a_q <= 1'b0;
      neg_q_q  <= 1'b0;
    end else begin
      sign_a_q <= sign_a_d;
      neg_q_q  <= neg_q_d;
    end
  end

  always_comb begin
    sign_a_d = sign_a_q;
    neg_q_d  = neg_q_q;
    if (state_q == StIdle && start) begin
      sign_a_d = A_reg[WIDTH-1];
      neg_q_d  = A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
    end
  end
`else
  assign a_mag    = A_reg;
  assign b_mag    = B_reg;
  assign quot_fix = q_q;
  assign rem_fix  = p_q;
`endif

  // MSB of the (WIDTH+1)-bit difference is set exactly when the trial subtraction underflows.
  assign s    = {p_q, q_q[WIDTH-1]};
  assign diff = s - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quot_out    <= '0;
      rem_out     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      b_q         <= b_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
      quot_out    <= quot_d;
      rem_out     <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    b_d     = b_q;
    busy_d  = busy;
    done_d  = 1'b0;
    dbz_d   = div_by_zero;
    quot_d  = quot_out;
    rem_d   = rem_out;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          dbz_d  = 1'b0;
          b_d    = b_mag;
          cnt_d  = '0;
          p_d    = '0;
          if (B_reg == '0) begin
            // Raw dividend is kept so ZDIV can return it unchanged as the remainder.
            q_d     = A_reg;
            state_d = StZdiv;
          end else begin
            q_d     = a_mag;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!diff[WIDTH]) begin
          p_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        quot_d  = quot_fix;
        rem_d   = rem_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StZdiv: begin
        quot_d  = '0;
        rem_d   = q_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
